decod_arbiter: RTL and testbench
================================

# decod_arbiter

Sixteen-way round-robin arbiter that owns the 4-to-16 decoder select path: it picks one of 16 requesters, registers the winning 4-bit index, and drives the decoded one-hot grant vector. A grant is held until the owner releases it. It sits between the requesting agents and the shared resource selected by the decoder, replacing free-running select inputs with a sequenced, fair schedule.

## Interface
- N_REQ, 16, number of requesters; fixed at 16, the decoder width
- IDX_W, 4, index width, log2(N_REQ)
- MAX_HOLD, 64, cycles a grant may be held before forced revoke; used only with the timeout feature
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  16  request vector, bit i = requester i
- rel  in  1  release from current owner; ignored when no grant is active
- gnt  out  16  one-hot grant: gnt[i] = gnt_vld & (gnt_idx == i); all zero when idle
- gnt_idx  out  4  encoded index of the current owner
- gnt_vld  out  1  a grant is active
- revoked  out  1  one-cycle pulse, forced revoke by timeout (tied 0 when the feature is compiled out)

## Operation
- States: IDLE, BUSY.
- Reset: state IDLE, gnt=0, gnt_idx=0, gnt_vld=0, revoked=0, priority pointer ptr=0, hold counter=0.
- Arbitration: the search starts at ptr and wraps modulo 16; the first set req bit wins. After a grant to k, ptr = (k+1) mod 16. Index 15 wraps to 0.
- IDLE: if req != 0, load the winner into gnt_idx, set gnt_vld, and go to BUSY. If req == 0, stay in IDLE with outputs unchanged (gnt_idx keeps its last value, gnt_vld=0).
- BUSY: the grant is independent of req once issued. Dropping req does not end the grant; only rel or the timeout ends it.
- BUSY with rel=1: if any req bit is set, including the current owner's, re-arbitrate from the updated ptr and grant back-to-back in the same edge, staying in BUSY. Otherwise go to IDLE and set gnt_vld=0.
- A lone requester that re-requests after release is re-granted immediately (the pointer wraps back to it).
- rel in IDLE: no effect.
- rst has priority over every other input, including mid-grant. Ownership is lost without notice.

## Timing
- All outputs are registered. No combinational path from req or rel to any output.
- Request latency: req sampled at edge t in IDLE; gnt valid after edge t. Minimum latency is 1 cycle.
- Handover: rel sampled at edge t; the new owner's gnt is valid after edge t. There are zero idle cycles between owners.
- gnt is always one-hot or zero. It never shows two bits, and never glitches between owners across a cycle boundary.
- Hold counter: clears on every new grant and increments each BUSY cycle.

## Configuration
- DECOD_ARB_TIMEOUT_EN defined:
  - When the hold counter reaches MAX_HOLD-1 in BUSY with rel=0, the grant is treated as released on that edge.
  - revoked pulses for 1 cycle, and re-arbitration follows the rel rules.
  - rel and the timeout in the same cycle count as a normal release; revoked stays 0.
- DECOD_ARB_TIMEOUT_EN not defined:
  - No counter is built and revoked is tied to 0.
  - A grant is held indefinitely until rel.

## Structure
- Package decod_arb_pkg holds N_REQ, IDX_W, the state enum (IDLE, BUSY), and an idx-to-onehot decode function shared with the decoder users.
- Sub-module decod_rr_pick: purely combinational. It takes req and ptr and returns the winner index and any-request. The rotate-and-priority-encode lives here; the FSM, pointer, counter and output registers stay in decod_arbiter.

## Test plan
- Reset and idle: assert rst for 2 cycles with req=16'hFFFF, then release rst with req=0. Expect gnt=0, gnt_vld=0, gnt_idx=0 throughout. Then rst asserted mid-BUSY gives gnt=0 on the next cycle.
- Single request: req=16'h0020 at edge t. Expect gnt=16'h0020 and gnt_idx=5 after t. Drop req with rel held 0: the grant is held. Pulse rel: expect gnt=0 next cycle.
- Round-robin order: req=16'h8101 held constant, pulse rel each grant. Expect the sequence idx 0, 8, 15, 0, 8, with no gaps between grants.
- Wrap from 15: ptr at 15 with req=16'h8000 only. Expect a re-grant to 15 back-to-back on each rel. Adding req bit 0 gives order 15, 0.
- rel while idle: pulse rel with req=0. No state change, no gnt.
- Timeout (macro on, MAX_HOLD=4): req=16'h0003, never rel. Expect idx 0 for 4 cycles, revoked pulse, idx 1 for 4 cycles, then revoked and idx 0. With rel and the timeout coincident, revoked stays 0.

Source files
------------

// File: rtl/decod_arb_pkg.sv
// Shared definitions for the 16-way round-robin decoder arbiter.
//   N_REQ         : number of requesters (decoder width)
//   IDX_W         : encoded index width
//   arb_state_e   : arbiter FSM states
//   idx_to_onehot : 4-to-16 decode shared with decoder users
package decod_arb_pkg;

  localparam int unsigned N_REQ = 16;
  localparam int unsigned IDX_W = 4;

  typedef enum logic {
    StIdle,
    StBusy
  } arb_state_e;

  function automatic logic [N_REQ-1:0] idx_to_onehot(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] oh;
    oh      = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/decod_rr_pick.sv
// Combinational round-robin pick: searches req_i starting at ptr_i, wrapping
// modulo N_REQ, and returns the first set bit.
//   req_i : request vector
//   ptr_i : highest-priority index for this search
//   idx_o : winning index (0 when no request)
//   any_o : at least one request is set
module decod_rr_pick
  import decod_arb_pkg::*;
(
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [IDX_W-1:0] idx_o,
  output logic             any_o
);

  logic [IDX_W-1:0] cand;
  logic             found;

  always_comb begin
    any_o = |req_i;
    idx_o = '0;
    cand  = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      // IDX_W-bit add wraps naturally modulo N_REQ
      cand = ptr_i + IDX_W'(i);
      if (!found && req_i[cand]) begin
        idx_o = cand;
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/decod_arbiter.sv
// Sixteen-way round-robin arbiter driving a registered 4-to-16 one-hot grant.
// A grant is held until rel (or, optionally, a hold timeout); on release the
// next owner is granted on the same edge.
// Optional feature macro: DECOD_ARB_TIMEOUT_EN (hold timeout after MAX_HOLD cycles).
//   clk     : clock
//   rst     : synchronous active-high reset
//   req     : request vector
//   rel     : release from current owner
//   gnt     : one-hot grant (zero when idle)
//   gnt_idx : encoded owner index
//   gnt_vld : grant active
//   revoked : one-cycle pulse on timeout revoke (0 without the feature)
module decod_arbiter
  import decod_arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             rel,
  output logic [N_REQ-1:0] gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld,
  output logic             revoked
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             vld_q, vld_d;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [IDX_W-1:0] win_idx;
  logic             win_any;
  logic             new_grant;
  logic             timeout_hit;

  decod_rr_pick u_pick (
    .req_i (req),
    .ptr_i (ptr_q),
    .idx_o (win_idx),
    .any_o (win_any)
  );

`ifdef DECOD_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(MAX_HOLD + 1);

  logic [CntW-1:0] cnt_q;
  logic            revoked_q;

  // rel in the same cycle wins, so a coincident timeout is a plain release
  assign timeout_hit = (state_q == StBusy) && !rel && (cnt_q == CntW'(MAX_HOLD - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      revoked_q <= 1'b0;
    end else begin
      revoked_q <= timeout_hit;
      if (new_grant) begin
        cnt_q <= '0;
      end else if (state_q == StBusy) begin
        cnt_q <= cnt_q + CntW'(1);
      end
    end
  end

  assign revoked = revoked_q;
`else
  logic unused_max_hold;
  assign unused_max_hold = ^MAX_HOLD;
  assign timeout_hit     = 1'b0;
  assign revoked         = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    idx_d     = idx_q;
    vld_d     = vld_q;
    new_grant = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (win_any) new_grant = 1'b1;
      end
      StBusy: begin
        // req is ignored while held; only a release re-arbitrates
        if (rel || timeout_hit) begin
          if (win_any) begin
            new_grant = 1'b1;
          end else begin
            state_d = StIdle;
            vld_d   = 1'b0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        vld_d   = 1'b0;
      end
    endcase
    if (new_grant) begin
      state_d = StBusy;
      idx_d   = win_idx;
      vld_d   = 1'b1;
      ptr_d   = win_idx + IDX_W'(1);
    end
    gnt_d = vld_d ? idx_to_onehot(idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      vld_q   <= 1'b0;
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      vld_q   <= vld_d;
      gnt_q   <= gnt_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = idx_q;
  assign gnt_vld = vld_q;

endmodule

// File: tb/tb_decod_arbiter.sv
module tb_decod_arbiter;

  localparam int MAX_HOLD = 4;
`ifdef DECOD_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [15:0] req;
  logic        rel;
  logic [15:0] gnt;
  logic [3:0]  gnt_idx;
  logic        gnt_vld;
  logic        revoked;

  int n_checks;
  int n_fail;

  // reference model state
  int m_idx, m_ptr, m_cnt;
  bit m_vld, m_rev;

  decod_arbiter #(
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .rel     (rel),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .revoked (revoked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] m_gnt();
    logic [15:0] v;
    v = '0;
    if (m_vld) v[m_idx] = 1'b1;
    return v;
  endfunction

  task automatic model_grant();
    for (int k = 0; k < 16; k++) begin
      if (req[(m_ptr + k) % 16]) begin
        m_idx = (m_ptr + k) % 16;
        break;
      end
    end
    m_ptr = (m_idx + 1) % 16;
    m_vld = 1'b1;
    m_cnt = 0;
  endtask

  // apply the arbitration rules for one rising edge using the present inputs
  task automatic model_edge();
    bit tmo;
    if (rst) begin
      m_idx = 0; m_ptr = 0; m_cnt = 0; m_vld = 1'b0; m_rev = 1'b0;
    end else begin
      tmo   = TO_EN && m_vld && !rel && (m_cnt == MAX_HOLD - 1);
      m_rev = tmo;
      if (!m_vld) begin
        if (req != 0) model_grant();
      end else if (rel || tmo) begin
        if (req != 0) model_grant();
        else m_vld = 1'b0;
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 16'hFFFF; rel = 1'b0;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_checks++;
      if ({gnt, gnt_idx, gnt_vld} !== 21'd0) begin
        n_fail++;
        $display("FAIL reset_hold: gnt=%h idx=%0d vld=%b, want all zero", gnt, gnt_idx, gnt_vld);
      end
    end
    rst = 1'b0; req = 16'h0000;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_checks++;
      if ({gnt, gnt_idx, gnt_vld, revoked} !== 22'd0) begin
        n_fail++;
        $display("FAIL reset_idle: gnt=%h idx=%0d vld=%b rev=%b, want all zero",
                 gnt, gnt_idx, gnt_vld, revoked);
      end
    end
  endtask

  task automatic test_single();
    req = 16'h0020;
    cyc();
    n_checks++;
    if (gnt !== 16'h0020 || gnt_idx !== 4'd5 || gnt_vld !== 1'b1) begin
      n_fail++;
      $display("FAIL single_grant: gnt=%h idx=%0d vld=%b, want 0020/5/1", gnt, gnt_idx, gnt_vld);
    end
    req = 16'h0000;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++;
      if (gnt !== 16'h0020 || gnt_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL single_hold: gnt=%h vld=%b, want 0020/1", gnt, gnt_vld);
      end
    end
    rel = 1'b1;
    cyc();
    rel = 1'b0;
    n_checks++;
    if (gnt !== 16'h0000 || gnt_vld !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: gnt=%h vld=%b, want 0000/0", gnt, gnt_vld);
    end
  endtask

  task automatic test_rel_idle();
    req = 16'h0000; rel = 1'b1;
    cyc();
    rel = 1'b0;
    n_checks++;
    if (gnt !== 16'h0000 || gnt_vld !== 1'b0 || gnt_idx !== 4'd5) begin
      n_fail++;
      $display("FAIL rel_idle: gnt=%h vld=%b idx=%0d, want 0000/0/5", gnt, gnt_vld, gnt_idx);
    end
    // pointer must still be 6 after the earlier grant to 5
    req = 16'hFFFF;
    cyc();
    n_checks++;
    if (gnt_idx !== 4'd6 || gnt !== 16'h0040) begin
      n_fail++;
      $display("FAIL rel_idle_ptr: idx=%0d gnt=%h, want 6/0040", gnt_idx, gnt);
    end
    req = 16'h0000; rel = 1'b1;
    cyc();
    rel = 1'b0;
  endtask

  task automatic test_rr_order();
    int exp_seq[5] = '{0, 8, 15, 0, 8};
    rst = 1'b1; cyc(); rst = 1'b0;
    req = 16'h8101; rel = 1'b0;
    cyc();
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if (gnt_idx !== 4'(exp_seq[i]) || gnt_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_order[%0d]: idx=%0d vld=%b, want %0d/1", i, gnt_idx, gnt_vld, exp_seq[i]);
      end
      rel = 1'b1;
      if (i < 4) cyc();
    end
    req = 16'h0000;
    cyc();
    rel = 1'b0;
  endtask

  task automatic test_wrap15();
    logic [15:0] reqs[5] = '{16'h4000, 16'h8000, 16'h8000, 16'h8001, 16'h8001};
    int          exp_seq[5] = '{14, 15, 15, 0, 15};
    rst = 1'b1; cyc(); rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      req = reqs[i];
      rel = (i > 0);
      cyc();
      n_checks++;
      if (gnt_idx !== 4'(exp_seq[i]) || gnt_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL wrap15[%0d]: idx=%0d vld=%b, want %0d/1", i, gnt_idx, gnt_vld, exp_seq[i]);
      end
    end
    req = 16'h0000; rel = 1'b1;
    cyc();
    rel = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    req = 16'h0100;
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0; req = 16'h0000;
    n_checks++;
    if ({gnt, gnt_idx, gnt_vld} !== 21'd0) begin
      n_fail++;
      $display("FAIL reset_mid_busy: gnt=%h idx=%0d vld=%b, want all zero", gnt, gnt_idx, gnt_vld);
    end
  endtask

`ifdef DECOD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    // after the grant edge: 4 cycles per owner, revoke on each handover
    int exp_idx[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0};
    bit exp_rev[12] = '{0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0};
    rst = 1'b1; cyc(); rst = 1'b0;
    req = 16'h0003; rel = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc();
      n_checks++;
      if (gnt_idx !== 4'(exp_idx[i]) || revoked !== exp_rev[i] || gnt_vld !== 1'b1) begin
        n_fail++;
        $display("FAIL timeout[%0d]: idx=%0d rev=%b vld=%b, want %0d/%b/1",
                 i, gnt_idx, revoked, gnt_vld, exp_idx[i], exp_rev[i]);
      end
    end
    // hold counter is at MAX_HOLD-1 now; rel coincides with timeout
    rel = 1'b1;
    cyc();
    rel = 1'b0;
    n_checks++;
    if (gnt_idx !== 4'd1 || revoked !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_coincident: idx=%0d rev=%b, want 1/0", gnt_idx, revoked);
    end
    req = 16'h0000; rel = 1'b1;
    cyc();
    rel = 1'b0;
  endtask
`else
  task automatic test_no_timeout();
    rst = 1'b1; cyc(); rst = 1'b0;
    req = 16'h0003; rel = 1'b0;
    for (int i = 0; i < 20; i++) begin
      cyc();
      n_checks++;
      if (gnt_idx !== 4'd0 || gnt_vld !== 1'b1 || revoked !== 1'b0) begin
        n_fail++;
        $display("FAIL no_timeout[%0d]: idx=%0d vld=%b rev=%b, want 0/1/0",
                 i, gnt_idx, gnt_vld, revoked);
      end
    end
    req = 16'h0000; rel = 1'b1;
    cyc();
    rel = 1'b0;
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 500; i++) begin
      rst = ($urandom_range(99) < 2);
      case ($urandom_range(3))
        0:       req = 16'h0000;
        1:       req = 16'(1 << $urandom_range(15));
        default: req = 16'($urandom) & 16'($urandom);
      endcase
      rel = ($urandom_range(99) < 30);
      cyc();
      n_checks++;
      if (gnt !== m_gnt() || gnt_vld !== m_vld || gnt_idx !== 4'(m_idx) || revoked !== m_rev
          || $countones(gnt) > 1) begin
        n_fail++;
        $display("FAIL random[%0d]: gnt=%h idx=%0d vld=%b rev=%b, want %h/%0d/%b/%b",
                 i, gnt, gnt_idx, gnt_vld, revoked, m_gnt(), m_idx, m_vld, m_rev);
      end
    end
    rst = 1'b0; rel = 1'b0; req = 16'h0000;
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    m_idx = 0; m_ptr = 0; m_cnt = 0; m_vld = 1'b0; m_rev = 1'b0;
    rst = 1'b1; req = 16'h0000; rel = 1'b0;
    test_reset();
    test_single();
    test_rel_idle();
    test_rr_order();
    test_wrap15();
    test_reset_mid_busy();
`ifdef DECOD_ARB_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
